// File: rtl/battle_engine_param.sv
// battle_engine_param: turn-based player-vs-enemy duel engine with ammo, defend and win flags.
// Optional CRIT_EN macro adds an LFSR-driven critical hit (doubled damage) and a crit_hit output.
module battle_engine_param #(
  parameter int HP_W       = 8,
  parameter int MAX_HP     = 100,
  parameter int AMMO_W     = 5,
  parameter int INIT_SWORD = 3,
  parameter int INIT_BAT   = 5,
  parameter int PUNCH_DMG  = 5,
  parameter int SWORD_DMG  = 20,
  parameter int BAT_DMG    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              collision_detected,
  input  logic              player_valid,
  input  logic [1:0]        player_choice,
  input  logic              enemy_valid,
  input  logic [1:0]        enemy_choice,
  output logic [HP_W-1:0]   player_HB,
  output logic [HP_W-1:0]   enemy_HB,
  output logic [AMMO_W-1:0] player_remained_sword,
  output logic [AMMO_W-1:0] player_remained_baseballbat,
  output logic [AMMO_W-1:0] enemy_remained_sword,
  output logic [AMMO_W-1:0] enemy_remained_baseballbat,
  output logic              player_turn,
  output logic              in_battle,
  output logic              move_reject,
  output logic              player_win,
  output logic              enemy_win
`ifdef CRIT_EN
  ,
  output logic              crit_hit
`endif
);
  typedef enum logic [2:0] {IDLE, P_WAIT, P_APPLY, E_WAIT, E_APPLY, OVER} state_t;
  localparam logic [HP_W-1:0]   HP0 = HP_W'(MAX_HP);
  localparam logic [AMMO_W-1:0] SW0 = AMMO_W'(INIT_SWORD);
  localparam logic [AMMO_W-1:0] BT0 = AMMO_W'(INIT_BAT);
  state_t state_q, state_d;
  logic [HP_W-1:0] php_q, php_d, ehp_q, ehp_d;
  logic [AMMO_W-1:0] ps_q, ps_d, pb_q, pb_d, es_q, es_d, eb_q, eb_d;
  logic [1:0] mv_q, mv_d;
  logic coll_q, pg_q, pg_d, eg_q, eg_d, rej_q, rej_d, pwin_q, pwin_d, ewin_q, ewin_d;
  logic pturn_q, pturn_d, inb_q, inb_d;
  logic rise, p_wait, e_wait, p_app, e_app, valid, empty, def, crit;
  logic [1:0] ch;
  logic [AMMO_W-1:0] sw, bt;
  logic [HP_W-1:0] base, sat, dmg, tgt_hp, new_hp;
  assign rise   = collision_detected & ~coll_q;
  assign p_wait = state_q == P_WAIT;
  assign e_wait = state_q == E_WAIT;
  assign p_app  = state_q == P_APPLY;
  assign e_app  = state_q == E_APPLY;
  assign valid  = (p_wait & player_valid) | (e_wait & enemy_valid);
  assign ch     = p_wait ? player_choice : enemy_choice;
  assign sw     = p_wait ? ps_q : es_q;
  assign bt     = p_wait ? pb_q : eb_q;
  assign empty  = (ch == 2'b01 && sw == '0) || (ch == 2'b10 && bt == '0);
  assign def    = mv_q == 2'b11;
  assign base   = mv_q == 2'b00 ? HP_W'(PUNCH_DMG) : mv_q == 2'b01 ? HP_W'(SWORD_DMG) : HP_W'(BAT_DMG);
`ifdef CRIT_EN
  logic [15:0] lfsr_q;
  logic crit_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign crit     = lfsr_q[2:0] == 3'b000;
  assign crit_hit = crit_q;
  // doubling saturates at the top of the HP range rather than wrapping
  assign sat = crit ? (base[HP_W-1] ? '1 : {base[HP_W-2:0], 1'b0}) : base;
`else
  assign crit = 1'b0;
  assign sat  = base;
`endif
  assign tgt_hp = p_app ? ehp_q : php_q;
  assign dmg    = (p_app ? eg_q : pg_q) ? sat >> 1 : sat;
  assign new_hp = def ? tgt_hp : (tgt_hp > dmg ? tgt_hp - dmg : '0);
  always_comb begin
    state_d = state_q;
    php_d = php_q;
    ehp_d = ehp_q;
    ps_d = ps_q;
    pb_d = pb_q;
    es_d = es_q;
    eb_d = eb_q;
    mv_d = mv_q;
    pg_d = pg_q;
    eg_d = eg_q;
    pwin_d = pwin_q;
    ewin_d = ewin_q;
    rej_d = 1'b0;
    if (rise && (state_q == IDLE || state_q == OVER)) begin
      state_d = P_WAIT;
      php_d = HP0;
      ehp_d = HP0;
      ps_d = SW0;
      pb_d = BT0;
      es_d = SW0;
      eb_d = BT0;
      pg_d = 1'b0;
      eg_d = 1'b0;
      pwin_d = 1'b0;
      ewin_d = 1'b0;
    end else if (valid) begin
      rej_d = empty;
      mv_d = empty ? mv_q : ch;
      state_d = empty ? state_q : (p_wait ? P_APPLY : E_APPLY);
    end else if (p_app) begin
      ehp_d = new_hp;
      eg_d = 1'b0;
      pg_d = pg_q | def;
      ps_d = ps_q - AMMO_W'(mv_q == 2'b01);
      pb_d = pb_q - AMMO_W'(mv_q == 2'b10);
      pwin_d = new_hp == '0;
      state_d = new_hp == '0 ? OVER : E_WAIT;
    end else if (e_app) begin
      php_d = new_hp;
      pg_d = 1'b0;
      eg_d = eg_q | def;
      es_d = es_q - AMMO_W'(mv_q == 2'b01);
      eb_d = eb_q - AMMO_W'(mv_q == 2'b10);
      ewin_d = new_hp == '0;
      state_d = new_hp == '0 ? OVER : P_WAIT;
    end
    pturn_d = state_d == P_WAIT || state_d == P_APPLY;
    inb_d = state_d != IDLE && state_d != OVER;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      coll_q <= 1'b0;
      php_q <= HP0;
      ehp_q <= HP0;
      ps_q <= SW0;
      pb_q <= BT0;
      es_q <= SW0;
      eb_q <= BT0;
      mv_q <= 2'b00;
      pg_q <= 1'b0;
      eg_q <= 1'b0;
      rej_q <= 1'b0;
      pwin_q <= 1'b0;
      ewin_q <= 1'b0;
      pturn_q <= 1'b0;
      inb_q <= 1'b0;
`ifdef CRIT_EN
      crit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      coll_q <= collision_detected;
      php_q <= php_d;
      ehp_q <= ehp_d;
      ps_q <= ps_d;
      pb_q <= pb_d;
      es_q <= es_d;
      eb_q <= eb_d;
      mv_q <= mv_d;
      pg_q <= pg_d;
      eg_q <= eg_d;
      rej_q <= rej_d;
      pwin_q <= pwin_d;
      ewin_q <= ewin_d;
      pturn_q <= pturn_d;
      inb_q <= inb_d;
`ifdef CRIT_EN
      crit_q <= (p_app | e_app) & crit & ~def;
`endif
    end
  assign player_HB = php_q;
  assign enemy_HB = ehp_q;
  assign player_remained_sword = ps_q;
  assign player_remained_baseballbat = pb_q;
  assign enemy_remained_sword = es_q;
  assign enemy_remained_baseballbat = eb_q;
  assign player_turn = pturn_q;
  assign in_battle = inb_q;
  assign move_reject = rej_q;
  assign player_win = pwin_q;
  assign enemy_win = ewin_q;
endmodule

// File: tb/tb_battle_engine_param.sv
// tb_battle_engine_param: directed duel scenarios plus random play checked against a turn-level model.
module tb_battle_engine_param;
  logic clk = 1'b0, rst_n = 1'b0, coll = 1'b0, pv = 1'b0, ev = 1'b0;
  logic [1:0] pc = 2'b00, ec = 2'b00;
  logic [7:0] php_o, ehp_o;
  logic [4:0] ps_o, pb_o, es_o, eb_o;
  logic pturn_o, inb_o, rej_o, pwin_o, ewin_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  battle_engine_param dut (
    .clk(clk), .rst_n(rst_n), .collision_detected(coll),
    .player_valid(pv), .player_choice(pc), .enemy_valid(ev), .enemy_choice(ec),
    .player_HB(php_o), .enemy_HB(ehp_o),
    .player_remained_sword(ps_o), .player_remained_baseballbat(pb_o),
    .enemy_remained_sword(es_o), .enemy_remained_baseballbat(eb_o),
    .player_turn(pturn_o), .in_battle(inb_o), .move_reject(rej_o),
    .player_win(pwin_o), .enemy_win(ewin_o)
  );
  // phase: 0 idle, 1 player waiting, 2 player hit lands, 3 enemy waiting, 4 enemy hit lands, 5 over
  int m_php, m_ehp, m_ps, m_pb, m_es, m_eb, m_ph, m_pend;
  bit m_pg, m_eg, m_rej, m_pwin, m_ewin, m_prev;
  int dmg_tab[4] = '{5, 20, 12, 0};
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void m_reload();
    m_php = 100; m_ehp = 100; m_ps = 3; m_pb = 5; m_es = 3; m_eb = 5;
    m_pg = 0; m_eg = 0; m_pwin = 0; m_ewin = 0;
  endfunction
  function automatic void m_reset();
    m_reload();
    m_ph = 0; m_pend = 0; m_rej = 0; m_prev = 0;
  endfunction
  function automatic int hit(input int hp, input int mv, input bit guard);
    int d = guard ? dmg_tab[mv] / 2 : dmg_tab[mv];
    return hp > d ? hp - d : 0;
  endfunction
  function automatic bit no_ammo(input int c, input int s, input int b);
    return (c == 1 && s == 0) || (c == 2 && b == 0);
  endfunction
  function automatic void model(input bit c, input bit vp, input int cp, input bit ve, input int ce);
    bit rise = c && !m_prev;
    m_prev = c;
    m_rej = 0;
    if (rise && (m_ph == 0 || m_ph == 5)) begin
      m_reload();
      m_ph = 1;
    end else if (m_ph == 1 && vp) begin
      if (no_ammo(cp, m_ps, m_pb)) m_rej = 1;
      else begin m_pend = cp; m_ph = 2; end
    end else if (m_ph == 3 && ve) begin
      if (no_ammo(ce, m_es, m_eb)) m_rej = 1;
      else begin m_pend = ce; m_ph = 4; end
    end else if (m_ph == 2) begin
      if (m_pend == 3) m_pg = 1;
      else m_ehp = hit(m_ehp, m_pend, m_eg);
      m_eg = 0;
      if (m_pend == 1) m_ps--;
      if (m_pend == 2) m_pb--;
      m_pwin = m_ehp == 0;
      m_ph = m_pwin ? 5 : 3;
    end else if (m_ph == 4) begin
      if (m_pend == 3) m_eg = 1;
      else m_php = hit(m_php, m_pend, m_pg);
      m_pg = 0;
      if (m_pend == 1) m_es--;
      if (m_pend == 2) m_eb--;
      m_ewin = m_php == 0;
      m_ph = m_ewin ? 5 : 1;
    end
  endfunction
  task automatic compare_all();
    check("player_HB", php_o, m_php);
    check("enemy_HB", ehp_o, m_ehp);
    check("p_sword", ps_o, m_ps);
    check("p_bat", pb_o, m_pb);
    check("e_sword", es_o, m_es);
    check("e_bat", eb_o, m_eb);
    check("player_turn", pturn_o, int'(m_ph == 1 || m_ph == 2));
    check("in_battle", inb_o, int'(m_ph >= 1 && m_ph <= 4));
    check("move_reject", rej_o, m_rej);
    check("player_win", pwin_o, m_pwin);
    check("enemy_win", ewin_o, m_ewin);
  endtask
  task automatic step(input bit c, input bit vp, input logic [1:0] cp, input bit ve, input logic [1:0] ce);
    coll = c; pv = vp; pc = cp; ev = ve; ec = ce;
    model(c, vp, cp, ve, ce);
    @(negedge clk);
    compare_all();
  endtask
  task automatic pmove(input logic [1:0] c);
    step(0, 1, c, 0, 2'b00);
    step(0, 0, 2'b00, 0, 2'b00);
  endtask
  task automatic emove(input logic [1:0] c);
    step(0, 0, 2'b00, 1, c);
    step(0, 0, 2'b00, 0, 2'b00);
  endtask
  initial begin
    m_reset();
    #12 compare_all();
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("start_turn", pturn_o, 1);
    check("start_hp", ehp_o, 100);
    pmove(2'b01);
    check("sword_hit", ehp_o, 80);
    check("sword_left", ps_o, 2);
    emove(2'b00); pmove(2'b01);
    emove(2'b00); pmove(2'b01);
    emove(2'b00);
    step(0, 1, 2'b01, 0, 0);
    check("reject_pulse", rej_o, 1);
    check("reject_hp", ehp_o, 40);
    check("reject_turn", pturn_o, 1);
    step(0, 0, 0, 0, 0);
    check("reject_once", rej_o, 0);
    pmove(2'b00);
    emove(2'b11); pmove(2'b10);
    check("guard_half", ehp_o, 29);
    emove(2'b00); pmove(2'b10);
    check("guard_gone", ehp_o, 17);
    emove(2'b00); pmove(2'b00);
    emove(2'b11); pmove(2'b10);
    emove(2'b11); pmove(2'b00);
    check("enemy_at_4", ehp_o, 4);
    emove(2'b00); pmove(2'b00);
    check("sat_zero", ehp_o, 0);
    check("win", pwin_o, 1);
    check("over", inb_o, 0);
    step(0, 1, 2'b01, 1, 2'b01);
    step(0, 1, 2'b00, 1, 2'b10);
    step(1, 0, 0, 0, 0);
    pmove(2'b10);
    step(0, 0, 0, 1, 2'b01);
    rst_n = 1'b0;
    coll = 1'b0; pv = 1'b0; ev = 1'b0;
    m_reset();
    #1 compare_all();
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 0, 0, 0);
    check("restart_turn", pturn_o, 1);
    check("restart_hp", php_o, 100);
    for (int i = 0; i < 4000; i++)
      step(coll ^ ($urandom_range(0, 24) == 0), 1'($urandom), 2'($urandom),
           1'($urandom), 2'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/battle_engine_param.md
Name: battle_engine_param

Overview:
- Parametrised successor to the turn-based combat engine. Runs a full player-vs-enemy duel once the map layer reports a collision.
- Alternates turns through a state machine and accepts each side's move via a valid strobe.
- Applies saturating damage with per-weapon ammo, a defend move that halves the next incoming hit, and win flags.
- Sits between the collision detector / input decoders and the HUD/display logic.

Parameters:
- HP_W, 8, width of health registers
- MAX_HP, 100, starting health for both sides (must fit in HP_W)
- AMMO_W, 5, width of weapon-use counters
- INIT_SWORD, 3, starting sword uses per side
- INIT_BAT, 5, starting bat uses per side
- PUNCH_DMG, 5, damage of move 00
- SWORD_DMG, 20, damage of move 01
- BAT_DMG, 12, damage of move 10

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- collision_detected  in  1  level; a rising edge starts a battle
- player_valid  in  1  player move strobe
- player_choice  in  2  00 punch, 01 sword, 10 bat, 11 defend
- enemy_valid  in  1  enemy move strobe
- enemy_choice  in  2  same encoding as player_choice
- player_HB  out  HP_W  player health
- enemy_HB  out  HP_W  enemy health
- player_remained_sword  out  AMMO_W  player sword uses left
- player_remained_baseballbat  out  AMMO_W  player bat uses left
- enemy_remained_sword  out  AMMO_W  enemy sword uses left
- enemy_remained_baseballbat  out  AMMO_W  enemy bat uses left
- player_turn  out  1  1 while waiting for the player's move
- in_battle  out  1  1 in any state except IDLE and OVER
- move_reject  out  1  one-cycle pulse: the chosen weapon has no uses left
- player_win  out  1  sticky until the next battle starts
- enemy_win  out  1  sticky until the next battle starts

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state IDLE; HB outputs = MAX_HP; counters = INIT_*.
  - player_turn, in_battle, move_reject, both win flags = 0; guard flags cleared.
- States: IDLE, P_WAIT, P_APPLY, E_WAIT, E_APPLY, OVER.
- Battle start:
  - A collision_detected rising edge is detected with a registered previous value.
  - In IDLE or OVER it reloads HP and ammo, clears win flags and guards, and goes to P_WAIT. The player always moves first.
  - Rising edges in any other state are ignored.
- Move acceptance:
  - In P_WAIT, player_valid=1 samples player_choice.
  - Sword or bat with counter=0: move_reject pulses on the next cycle, state stays P_WAIT, no HP change.
  - Otherwise the move is latched and the state goes to P_APPLY.
  - E_WAIT mirrors this with the enemy_* inputs.
  - The off-turn side's valid is ignored, including when both strobe together. Valid outside WAIT states is ignored.
- Apply (one cycle):
  - Punch, sword or bat: damage D, halved by floor (D>>1) if the target's guard flag is set, then the target's guard is cleared.
  - Target HP = HP - D if HP > D, else 0 (saturating, never wraps).
  - Sword and bat decrement the mover's counter by 1.
  - Defend sets the mover's guard flag and deals no damage. Guard persists only until the opponent's next apply.
- Timing:
  - A move accepted at edge N updates HP and counters at edge N+1.
  - At edge N+1 the state goes to the other side's WAIT, or to OVER if the target's HP reached 0.
- End of battle:
  - Entering OVER sets player_win (enemy HP 0) or enemy_win (player HP 0). Both flags can never be set together.
  - HP and counters hold until a new battle starts.
- Outputs:
  - player_turn = 1 exactly in P_WAIT and P_APPLY.
  - All outputs are registered.
- Reset mid-battle: immediate return to reset values; the latched move is discarded.

Optional Feature:
- Macro CRIT_EN.
- When defined:
  - A 16-bit Galois LFSR, seed 16'hACE1 on reset, advances every clock.
  - If LFSR[2:0]==3'b000 during an apply cycle, the damage is doubled before the guard halving.
  - The result is saturated to the HP_W range before subtraction.
  - Extra output crit_hit (1 bit) pulses for one cycle, aligned with the HP update.
- When undefined: no LFSR, no crit_hit port, damage is exactly as above.
- Test Plan scenarios assume CRIT_EN undefined.

Test Plan:
- Reset, then a collision rising edge → player_turn=1, in_battle=1, both HB=100, counters 3/5/3/5.
- Player sword (01) valid one cycle → after the next edge enemy_HB=80, player_remained_sword=2, player_turn=0.
- Player uses sword 3 times (enemy punches in between), then tries sword again → move_reject pulses once, state stays P_WAIT, enemy_HB unchanged at 40.
- Enemy defends (11), then player bat → enemy_HB drops by 6, not 12. A second bat with no new defend drops it by the full 12.
- Enemy at 4 HP, player punch (5) → enemy_HB=0 (no wrap to 255), player_win=1, in_battle=0. Further valids are ignored.
- Reset asserted mid-E_APPLY → all outputs return to reset values at once. A new collision edge restarts with player_turn=1 and both HB=100.
